// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - ENTER/LEAVE stack-frame sequencer driving EBP writes and stack memory
// Optional build macro: FRAME_ALIGN_EN rounds the ENTER frame size up to a multiple of 4.
module frame_sequencer #(
    parameter logic [31:0] ESP_RESET = 32'h0000_1000,
    parameter int          IMM_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [IMM_W-1:0] cmd_imm,
    input  logic [31:0]      ebp_in,
    output logic [3:0]       ebp_rw,
    output logic [31:0]      ebp_wdata,
    output logic [31:0]      esp,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_ack,
    input  logic [31:0]      mem_rdata,
    output logic             done
);

    localparam logic [1:0] OP_ENTER = 2'b01;
    localparam logic [1:0] OP_LEAVE = 2'b10;

    localparam logic [3:0] RW_NONE  = 4'h0;
    localparam logic [3:0] RW_SET   = 4'h2;
    localparam logic [3:0] RW_POP   = 4'h5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_E_PUSH,
        S_E_SET,
        S_E_ALLOC,
        S_L_MOVE,
        S_L_POP,
        S_L_SET,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        esp_q, esp_d;
    logic [IMM_W-1:0]   imm_q;
    logic [31:0]        ebp_q;
    logic [31:0]        rdata_q;
    logic [31:0]        ebp_wdata_q, ebp_wdata_d;
    logic               accept;
    logic               pop_ack;
    logic [31:0]        imm_ext;
    logic [31:0]        frame_size;

    // Frame size is the immediate zero-extended to the stack-pointer width.
    assign imm_ext = {{(32-IMM_W){1'b0}}, imm_q};

`ifdef FRAME_ALIGN_EN
    assign frame_size = (imm_ext + 32'd3) & ~32'd3;
`else
    assign frame_size = imm_ext;
`endif

    assign esp       = esp_q;
    assign ebp_wdata = ebp_wdata_d;

    // Next-state, stack-pointer update and all handshake/command outputs.
    always_comb begin
        state_d     = state_q;
        esp_d       = esp_q;
        ebp_wdata_d = ebp_wdata_q;
        ebp_rw      = RW_NONE;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = 32'h0;
        mem_wdata   = 32'h0;
        cmd_ready   = 1'b0;
        done        = 1'b0;
        accept      = 1'b0;
        pop_ack     = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept = 1'b1;
                    case (cmd_op)
                        OP_ENTER: state_d = S_E_PUSH;
                        OP_LEAVE: state_d = S_L_MOVE;
                        default:  state_d = S_DONE;
                    endcase
                end
            end
            S_E_PUSH: begin
                // Push the caller's EBP; request stays up until acknowledged.
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = esp_q - 32'd4;
                mem_wdata = ebp_q;
                if (mem_ack) begin
                    esp_d   = esp_q - 32'd4;
                    state_d = S_E_SET;
                end
            end
            S_E_SET: begin
                ebp_rw      = RW_SET;
                ebp_wdata_d = esp_q;
                state_d     = S_E_ALLOC;
            end
            S_E_ALLOC: begin
                esp_d   = esp_q - frame_size;
                state_d = S_DONE;
            end
            S_L_MOVE: begin
                esp_d   = ebp_q;
                state_d = S_L_POP;
            end
            S_L_POP: begin
                mem_req  = 1'b1;
                mem_we   = 1'b0;
                mem_addr = esp_q;
                if (mem_ack) begin
                    pop_ack = 1'b1;
                    esp_d   = esp_q + 32'd4;
                    state_d = S_L_SET;
                end
            end
            S_L_SET: begin
                ebp_rw      = RW_POP;
                ebp_wdata_d = rdata_q;
                state_d     = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, stack pointer and last EBP write data; reset overrides any in-flight ack.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            esp_q       <= ESP_RESET;
            ebp_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            esp_q       <= esp_d;
            ebp_wdata_q <= ebp_wdata_d;
        end
    end

    // Command operands are latched at accept so later ebp_in changes are ignored.
    always_ff @(posedge clock) begin
        if (reset) begin
            imm_q <= '0;
            ebp_q <= 32'h0;
        end else if (accept) begin
            imm_q <= cmd_imm;
            ebp_q <= ebp_in;
        end
    end

    // Popped word is held for the EBP write that follows the read.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_q <= 32'h0;
        end else if (pop_ack) begin
            rdata_q <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - randomized model-checked bench for frame_sequencer
module tb_frame_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [15:0] cmd_imm = 16'h0;
    logic [31:0] ebp_in = 32'h0;
    logic [3:0]  ebp_rw;
    logic [31:0] ebp_wdata;
    logic [31:0] esp;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        done;

    frame_sequencer #(.ESP_RESET(32'h0000_1000), .IMM_W(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_imm   (cmd_imm),
        .ebp_in    (ebp_in),
        .ebp_rw    (ebp_rw),
        .ebp_wdata (ebp_wdata),
        .esp       (esp),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .done      (done)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Memory responder settings for the current command.
    int          cur_waits = 0;
    logic [31:0] cur_rdata = 32'h0;
    int          wcnt = 0;

    // Reference state kept at the architectural level.
    logic [31:0] model_esp   = 32'h0000_1000;
    logic [31:0] last_wdata  = 32'h0;

    // Observations from the most recent command.
    logic [31:0] rec_addr, rec_wdata, rec_rwdata, rec_esp;
    logic        rec_we;
    logic [3:0]  rec_rw;
    int          rec_done;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enter_size(input logic [15:0] imm);
        logic [31:0] s;
        s = {16'h0, imm};
`ifdef FRAME_ALIGN_EN
        s = (s + 32'd3) & ~32'd3;
`endif
        return s;
    endfunction

    // Acknowledges a request after cur_waits stall cycles.
    always @(negedge clock) begin
        if (mem_req === 1'b1) begin
            if (wcnt >= cur_waits) begin
                mem_ack   = 1'b1;
                mem_rdata = cur_rdata;
                wcnt      = 0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
                wcnt++;
            end
        end else begin
            mem_ack = 1'b0;
            wcnt    = 0;
        end
    end

    task automatic run_cmd(input logic [1:0] op, input logic [15:0] imm, input logic [31:0] ebp,
                           input int waits, input logic [31:0] rdata);
        logic        exp_txn, exp_we;
        logic [31:0] exp_addr, exp_wd, exp_rwd, exp_esp;
        logic [3:0]  exp_rw;
        int          exp_done;
        int          req_cycles, rw_count, stable_bad, busy_ready;

        case (op)
            2'b01: begin
                exp_txn = 1'b1; exp_we = 1'b1;
                exp_addr = model_esp - 32'd4; exp_wd = ebp;
                exp_rw = 4'h2; exp_rwd = model_esp - 32'd4;
                exp_esp = model_esp - 32'd4 - enter_size(imm);
                exp_done = 4 + waits;
            end
            2'b10: begin
                exp_txn = 1'b1; exp_we = 1'b0;
                exp_addr = ebp; exp_wd = 32'h0;
                exp_rw = 4'h5; exp_rwd = rdata;
                exp_esp = ebp + 32'd4;
                exp_done = 4 + waits;
            end
            default: begin
                exp_txn = 1'b0; exp_we = 1'b0;
                exp_addr = 32'h0; exp_wd = 32'h0;
                exp_rw = 4'h0; exp_rwd = last_wdata;
                exp_esp = model_esp;
                exp_done = 1;
            end
        endcase

        @(negedge clock);
        check_eq("idle_ready", cmd_ready, 1'b1);
        check_eq("idle_done", done, 1'b0);
        cur_waits = waits;
        cur_rdata = rdata;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_imm   = imm;
        ebp_in    = ebp;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_imm   = 16'($urandom);
        ebp_in    = $urandom;

        req_cycles = 0; rw_count = 0; stable_bad = 0; busy_ready = 0;
        rec_done = -1; rec_rw = 4'h0; rec_rwdata = 32'h0;
        rec_addr = 32'h0; rec_we = 1'b0; rec_wdata = 32'h0; rec_esp = 32'h0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            if (cmd_ready) busy_ready++;
            if (mem_req) begin
                if (req_cycles == 0) begin
                    rec_addr = mem_addr; rec_we = mem_we; rec_wdata = mem_wdata;
                end else if (mem_addr !== rec_addr || mem_we !== rec_we || mem_wdata !== rec_wdata) begin
                    stable_bad++;
                end
                req_cycles++;
            end
            if (ebp_rw != 4'h0) begin
                rw_count++;
                rec_rw = ebp_rw;
                rec_rwdata = ebp_wdata;
            end
            if (done) begin
                rec_done = c;
                rec_esp  = esp;
                check_eq("hold_wdata", ebp_wdata, exp_rwd);
                break;
            end
        end

        check_eq("done_cycle", rec_done, exp_done);
        check_eq("busy_ready", busy_ready, 0);
        check_eq("req_cycles", req_cycles, exp_txn ? waits + 1 : 0);
        check_eq("final_esp", rec_esp, exp_esp);
        check_eq("rw_count", rw_count, (exp_rw != 4'h0) ? 1 : 0);
        if (exp_txn) begin
            check_eq("mem_addr", rec_addr, exp_addr);
            check_eq("mem_we", rec_we, exp_we);
            if (exp_we) check_eq("mem_wdata", rec_wdata, exp_wd);
            check_eq("req_stable", stable_bad, 0);
        end
        if (exp_rw != 4'h0) begin
            check_eq("ebp_rw", rec_rw, exp_rw);
            check_eq("ebp_wdata", rec_rwdata, exp_rwd);
        end

        model_esp  = exp_esp;
        last_wdata = exp_rwd;
    endtask

    int d1, d2, ready_early, rw_seen;

    initial begin
        // Reset held for two cycles.
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_eq("rst_esp", esp, 32'h0000_1000);
        check_eq("rst_ready", cmd_ready, 1'b1);
        check_eq("rst_ebp_rw", ebp_rw, 4'h0);
        check_eq("rst_mem_req", mem_req, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_ebp_wdata", ebp_wdata, 32'h0);

        // ENTER with a zero-wait memory.
        run_cmd(2'b01, 16'h0010, 32'h0000_0999, 0, 32'h0);
        check_eq("enter_addr", rec_addr, 32'h0000_0FFC);
        check_eq("enter_data", rec_wdata, 32'h0000_0999);
        check_eq("enter_set", rec_rwdata, 32'h0000_0FFC);
        check_eq("enter_esp", rec_esp, 32'h0000_0FEC);
        check_eq("enter_lat", rec_done, 4);

        // LEAVE with three wait cycles.
        run_cmd(2'b10, 16'h0, 32'h0000_0FFC, 3, 32'h0000_0999);
        check_eq("leave_addr", rec_addr, 32'h0000_0FFC);
        check_eq("leave_pop", rec_rwdata, 32'h0000_0999);
        check_eq("leave_esp", rec_esp, 32'h0000_1000);
        check_eq("leave_lat", rec_done, 7);

        // No-op.
        run_cmd(2'b11, 16'h1234, 32'h5555_AAAA, 0, 32'h0);
        check_eq("nop_lat", rec_done, 1);

        // Back-pressure: valid held high across an ENTER.
        @(negedge clock);
        cur_waits = 0;
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_imm = 16'h0004; ebp_in = 32'h1234_5678;
        @(posedge clock);
        #1 cmd_op = 2'b00;
        d1 = -1; d2 = -1; ready_early = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            if (cmd_ready && c < 5) ready_early++;
            if (done) begin
                if (d1 < 0) d1 = c;
                else if (d2 < 0) d2 = c;
            end
        end
        cmd_valid = 1'b0;
        check_eq("bp_ready_early", ready_early, 0);
        check_eq("bp_done1", d1, 4);
        check_eq("bp_done2", d2, 6);
        last_wdata = model_esp - 32'd4;
        model_esp  = model_esp - 32'd8;
        check_eq("bp_esp", esp, model_esp);

        // Wrap: pop from the top of the address space, then ENTER with size 0.
        run_cmd(2'b10, 16'h0, 32'hFFFF_FFFC, 1, 32'hCAFE_0001);
        check_eq("wrap_leave_esp", rec_esp, 32'h0000_0000);
        run_cmd(2'b01, 16'h0000, 32'h0BAD_F00D, 0, 32'h0);
        check_eq("wrap_push_addr", rec_addr, 32'hFFFF_FFFC);
        check_eq("wrap_esp", rec_esp, 32'hFFFF_FFFC);

        // Non-multiple-of-4 frame size.
        run_cmd(2'b01, 16'h0005, 32'h0000_1111, 2, 32'h0);

        // Randomized command mix.
        for (int i = 0; i < 40; i++) begin
            logic [15:0] imm;
            imm = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            run_cmd(2'($urandom_range(0, 3)), imm, $urandom, $urandom_range(0, 3), $urandom);
        end

        // Reset during E_PUSH with a coincident ack.
        @(negedge clock);
        cur_waits = 0;
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_imm = 16'h0020; ebp_in = 32'hDEAD_BEEF;
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        @(negedge clock);
        check_eq("rmid_in_push", mem_req, 1'b1);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_eq("rmid_esp", esp, 32'h0000_1000);
        check_eq("rmid_mem_req", mem_req, 1'b0);
        check_eq("rmid_ready", cmd_ready, 1'b1);
        rw_seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (ebp_rw != 4'h0 || done) rw_seen++;
            @(negedge clock);
        end
        check_eq("rmid_no_pulse", rw_seen, 0);
        model_esp  = 32'h0000_1000;
        last_wdata = 32'h0;

        run_cmd(2'b01, 16'h0008, 32'h0000_2222, 1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
